// File: rtl/pico_port_ctrl_if.sv
// kcpsm6 I/O bus as seen by the port/interrupt controller.
// The processor side drives strobes and data; the controller returns in_port and interrupt.
interface pico_port_ctrl_if;
   logic       write_strobe;
   logic       read_strobe;
   logic [7:0] port_id;
   logic [7:0] out_port;
   logic       interrupt_ack;
   logic [7:0] in_port;
   logic       interrupt;

   modport master (
      output write_strobe, read_strobe, port_id, out_port, interrupt_ack,
      input  in_port, interrupt
   );

   // read_strobe is informational only, so the controller does not take it
   modport slave (
      input  write_strobe, port_id, out_port, interrupt_ack,
      output in_port, interrupt
   );
endinterface

// File: rtl/pico_port_ctrl.sv
// Output-port decode, key command pulses, reset-pulse timer and edge-latched
// interrupt controller sitting between kcpsm6 and the clock/display datapath.
//
// state     | meaning
// S_IDLE    | no request outstanding; go to S_REQ when any bit is pending
// S_REQ     | interrupt asserted, waiting for interrupt_ack
// S_SERVICE | handler running; leave on any write to IRQ_PORT_ID
module pico_port_ctrl #(
   parameter logic [7:0] STATE_PORT_ID      = 8'h02,
   parameter logic [7:0] KEY_PORT_ID        = 8'h01,
   parameter logic [7:0] IRQ_PORT_ID        = 8'h03,
   parameter int         NUM_IRQ            = 2,
   parameter int         RESET_PULSE_CYCLES = 1044,
   parameter logic [7:0] KEY_UP             = 8'h57,
   parameter logic [7:0] KEY_DOWN           = 8'h53,
   parameter logic [7:0] KEY_LEFT           = 8'h41,
   parameter logic [7:0] KEY_RIGHT          = 8'h44,
   parameter logic [7:0] KEY_INSTR          = 8'h49,
   parameter logic [7:0] KEY_RST            = 8'h08
) (
   input  logic               clk,
   input  logic               reset,
   pico_port_ctrl_if.slave    bus,
   input  logic [7:0]         ext_in,
   input  logic [NUM_IRQ-1:0] event_in,
   output logic [7:0]         EstadoPort,
   output logic               sumar,
   output logic               restar,
   output logic               izquierda,
   output logic               derecha,
   output logic               instrucciones,
   output logic               resetO,
   output logic [NUM_IRQ-1:0] pending
);

   localparam int CW = $clog2(RESET_PULSE_CYCLES + 1);
   localparam logic [CW-1:0] RST_LOAD = CW'(RESET_PULSE_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} irq_state_t;

   irq_state_t         state_q, state_d;
   logic [7:0]         estado_q, estado_d;
   logic               sumar_q, sumar_d, restar_q, restar_d;
   logic               izq_q, izq_d, der_q, der_d;
   logic               instr_q, instr_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               reseto_q, reseto_d;
   logic               armed_q, armed_d;
   logic [NUM_IRQ-1:0] evt_prev_q, evt_prev_d;
   logic [NUM_IRQ-1:0] pending_q, pending_d;
   logic               irq_q, irq_d;

   logic               wr_state, wr_key, wr_irq;
   logic [NUM_IRQ-1:0] rise, clr;
   logic [7:0]         irq_rd;

   always_comb begin
      wr_state = bus.write_strobe && (bus.port_id == STATE_PORT_ID);
      wr_key   = bus.write_strobe && (bus.port_id == KEY_PORT_ID);
      wr_irq   = bus.write_strobe && (bus.port_id == IRQ_PORT_ID);

      estado_d = wr_state ? bus.out_port : estado_q;
      sumar_d  = wr_key && (bus.out_port == KEY_UP);
      restar_d = wr_key && (bus.out_port == KEY_DOWN);
      izq_d    = wr_key && (bus.out_port == KEY_LEFT);
      der_d    = wr_key && (bus.out_port == KEY_RIGHT);
      instr_d  = instr_q ^ (wr_key && (bus.out_port == KEY_INSTR));

      if (wr_key && (bus.out_port == KEY_RST))
         cnt_d = RST_LOAD;
      else if (cnt_q != '0)
         cnt_d = cnt_q - CW'(1);
      else
         cnt_d = cnt_q;
      reseto_d = (cnt_d != '0);

      // first edge after reset only primes the history, so a level held
      // high through reset release is not mistaken for an edge
      armed_d    = 1'b1;
      evt_prev_d = event_in;
      rise       = armed_q ? (event_in & ~evt_prev_q) : '0;
      clr        = wr_irq ? bus.out_port[NUM_IRQ-1:0] : '0;
      pending_d  = (pending_q & ~clr) | rise;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (pending_q != '0) state_d = S_REQ;
         S_REQ:     if (bus.interrupt_ack) state_d = S_SERVICE;
         S_SERVICE: if (wr_irq) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
      irq_d = (state_d == S_REQ);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         estado_q   <= '0;
         sumar_q    <= 1'b0;
         restar_q   <= 1'b0;
         izq_q      <= 1'b0;
         der_q      <= 1'b0;
         instr_q    <= 1'b0;
         cnt_q      <= '0;
         reseto_q   <= 1'b0;
         armed_q    <= 1'b0;
         evt_prev_q <= '0;
         pending_q  <= '0;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         estado_q   <= estado_d;
         sumar_q    <= sumar_d;
         restar_q   <= restar_d;
         izq_q      <= izq_d;
         der_q      <= der_d;
         instr_q    <= instr_d;
         cnt_q      <= cnt_d;
         reseto_q   <= reseto_d;
         armed_q    <= armed_d;
         evt_prev_q <= evt_prev_d;
         pending_q  <= pending_d;
         irq_q      <= irq_d;
      end
   end

   always_comb begin
      irq_rd              = '0;
      irq_rd[NUM_IRQ-1:0] = pending_q;
   end

   assign bus.in_port   = (bus.port_id == IRQ_PORT_ID) ? irq_rd : ext_in;
   assign bus.interrupt = irq_q;
   assign EstadoPort    = estado_q;
   assign sumar         = sumar_q;
   assign restar        = restar_q;
   assign izquierda     = izq_q;
   assign derecha       = der_q;
   assign instrucciones = instr_q;
   assign resetO        = reseto_q;
   assign pending       = pending_q;

endmodule

// File: tb/tb_pico_port_ctrl.sv
// Directed bench for pico_port_ctrl with a short reset pulse and two event sources.
module tb_pico_port_ctrl;
   logic       clk;
   logic       reset;
   logic [7:0] ext_in;
   logic [1:0] event_in;
   logic [7:0] EstadoPort;
   logic       sumar, restar, izquierda, derecha, instrucciones, resetO;
   logic [1:0] pending;
   logic [7:0] keys [4];
   int         n_chk, n_fail, hi;

   pico_port_ctrl_if bus ();

   pico_port_ctrl #(
      .NUM_IRQ(2),
      .RESET_PULSE_CYCLES(10)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .ext_in(ext_in),
      .event_in(event_in),
      .EstadoPort(EstadoPort),
      .sumar(sumar),
      .restar(restar),
      .izquierda(izquierda),
      .derecha(derecha),
      .instrucciones(instrucciones),
      .resetO(resetO),
      .pending(pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [7:0] pid, input logic [7:0] data);
      @(negedge clk);
      bus.write_strobe = 1'b1;
      bus.port_id      = pid;
      bus.out_port     = data;
      @(negedge clk);
      bus.write_strobe = 1'b0;
      bus.port_id      = 8'h00;
      bus.out_port     = 8'h00;
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      keys[0] = 8'h57; keys[1] = 8'h53; keys[2] = 8'h41; keys[3] = 8'h44;
      reset = 1'b0;
      ext_in = 8'h00;
      event_in = 2'b01;
      bus.write_strobe = 1'b0;
      bus.read_strobe = 1'b0;
      bus.port_id = 8'h00;
      bus.out_port = 8'h00;
      bus.interrupt_ack = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_estado", EstadoPort, 8'h00);
      chk("rst_pulses", {sumar, restar, izquierda, derecha}, 4'b0000);
      chk("rst_instr", instrucciones, 1'b0);
      chk("rst_reseto", resetO, 1'b0);
      chk("rst_pending", pending, 2'b00);
      chk("rst_irq", bus.interrupt, 1'b0);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("held_evt_no_edge", pending, 2'b00);
      chk("held_evt_no_irq", bus.interrupt, 1'b0);
      event_in = 2'b00;
      @(negedge clk);

      // state word
      wr(8'h02, 8'hA5);
      chk("estado_load", EstadoPort, 8'hA5);
      repeat (20) @(negedge clk);
      chk("estado_hold", EstadoPort, 8'hA5);
      wr(8'h07, 8'h3C);
      chk("estado_other_port", EstadoPort, 8'hA5);

      // key pulses on consecutive cycles
      @(negedge clk);
      bus.write_strobe = 1'b1;
      bus.port_id = 8'h01;
      bus.out_port = keys[0];
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("key_pulse", {sumar, restar, izquierda, derecha}, 4'b1000 >> i);
         if (i < 3) bus.out_port = keys[i + 1];
         else bus.write_strobe = 1'b0;
      end
      @(negedge clk);
      chk("key_no_write", {sumar, restar, izquierda, derecha}, 4'b0000);
      wr(8'h01, 8'h99);
      chk("key_unlisted", {sumar, restar, izquierda, derecha, instrucciones, resetO}, 6'b0);
      wr(8'h02, 8'h57);
      chk("key_wrong_port", sumar, 1'b0);

      // instruction toggle
      wr(8'h01, 8'h49);
      chk("instr_set", instrucciones, 1'b1);
      repeat (5) @(negedge clk);
      chk("instr_hold", instrucciones, 1'b1);
      wr(8'h01, 8'h49);
      chk("instr_clear", instrucciones, 1'b0);

      // reset pulse with retrigger four cycles after the first write
      wr(8'h01, 8'h08);
      hi = resetO ? 1 : 0;
      repeat (3) begin
         @(negedge clk);
         if (resetO) hi++;
      end
      bus.write_strobe = 1'b1;
      bus.port_id = 8'h01;
      bus.out_port = 8'h08;
      @(negedge clk);
      bus.write_strobe = 1'b0;
      bus.port_id = 8'h00;
      bus.out_port = 8'h00;
      if (resetO) hi++;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (!resetO) break;
         hi++;
      end
      chk("reseto_len_retrig", hi, 14);
      chk("reseto_ended", resetO, 1'b0);
      chk("reseto_no_toggle", instrucciones, 1'b0);

      // asynchronous abort mid-pulse
      wr(8'h01, 8'h08);
      repeat (3) @(negedge clk);
      chk("reseto_mid", resetO, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk("reseto_async_abort", resetO, 1'b0);
      chk("estado_async_clear", EstadoPort, 8'h00);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // interrupt flow
      event_in = 2'b10;
      @(negedge clk);
      chk("evt1_pending", pending, 2'b10);
      chk("evt1_irq_lag", bus.interrupt, 1'b0);
      @(negedge clk);
      chk("evt1_irq", bus.interrupt, 1'b1);
      bus.interrupt_ack = 1'b1;
      @(negedge clk);
      bus.interrupt_ack = 1'b0;
      chk("ack_irq_low", bus.interrupt, 1'b0);
      event_in = 2'b11;
      repeat (3) @(negedge clk);
      chk("service_no_reassert", bus.interrupt, 1'b0);
      chk("service_pending", pending, 2'b11);
      bus.port_id = 8'h03;
      bus.read_strobe = 1'b1;
      ext_in = 8'h5A;
      #1;
      chk("read_pending", bus.in_port, 8'h03);
      bus.port_id = 8'h04;
      #1;
      chk("read_ext", bus.in_port, 8'h5A);
      bus.read_strobe = 1'b0;
      bus.port_id = 8'h00;
      @(negedge clk);
      chk("read_no_side_effect", pending, 2'b11);
      wr(8'h03, 8'h02);
      chk("w1c_bit1", pending, 2'b01);
      @(negedge clk);
      chk("irq_reassert", bus.interrupt, 1'b1);
      bus.interrupt_ack = 1'b1;
      @(negedge clk);
      bus.interrupt_ack = 1'b0;
      chk("ack2_irq_low", bus.interrupt, 1'b0);
      wr(8'h03, 8'h01);
      chk("w1c_bit0", pending, 2'b00);
      repeat (3) @(negedge clk);
      chk("idle_no_irq", bus.interrupt, 1'b0);

      // set and clear of the same bit in one cycle
      event_in = 2'b00;
      repeat (2) @(negedge clk);
      event_in = 2'b10;
      bus.write_strobe = 1'b1;
      bus.port_id = 8'h03;
      bus.out_port = 8'h02;
      @(negedge clk);
      bus.write_strobe = 1'b0;
      bus.port_id = 8'h00;
      bus.out_port = 8'h00;
      chk("set_wins", pending, 2'b10);
      @(negedge clk);
      chk("set_wins_irq", bus.interrupt, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/pico_port_ctrl.md
# pico_port_ctrl

Parametrised output-port and interrupt controller for the kcpsm6 soft processor. It decodes processor writes into a registered state-machine word, one-cycle key command pulses, a toggled instruction-enable flag and a fixed-length reset pulse. It latches up to eight external event sources into a pending-interrupt vector that drives the processor's `interrupt` input, with ack-based masking and write-1-to-clear. It also muxes the pending vector or external data onto the processor's `in_port`. It sits between kcpsm6 and the clock/display datapath.

## Interface
- `STATE_PORT_ID`, 8'h02, port id loading `EstadoPort`
- `KEY_PORT_ID`, 8'h01, port id carrying key codes
- `IRQ_PORT_ID`, 8'h03, port id for pending-vector read and write-1-to-clear
- `NUM_IRQ`, 2, number of event sources, legal 1..8
- `RESET_PULSE_CYCLES`, 1044, length of `resetO` pulse, legal ≥1
- `KEY_UP`, `KEY_DOWN`, `KEY_LEFT`, `KEY_RIGHT`, `KEY_INSTR`, `KEY_RST`: 8'h57, 8'h53, 8'h41, 8'h44, 8'h49, 8'h08
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `write_strobe`  in  1  kcpsm6 output strobe
- `read_strobe`  in  1  kcpsm6 input strobe, informational only
- `port_id`  in  8  kcpsm6 port id
- `out_port`  in  8  kcpsm6 output data
- `interrupt_ack`  in  1  kcpsm6 interrupt acknowledge
- `ext_in`  in  8  external data returned for non-IRQ port reads
- `event_in`  in  NUM_IRQ  level event sources, already synchronous to `clk`
- `in_port`  out  8  combinational read mux to kcpsm6
- `interrupt`  out  1  registered interrupt request
- `EstadoPort`  out  8  registered state word
- `sumar`, `restar`, `izquierda`, `derecha`  out  1 each  one-cycle command pulses
- `instrucciones`  out  1  registered toggle flag
- `resetO`  out  1  registered reset pulse
- `pending`  out  NUM_IRQ  pending-event vector, for debug

## Operation
- A write is a cycle with `write_strobe`=1. Port ids other than the three parameter ids are ignored.
- State write: `EstadoPort` <= `out_port`. The value holds otherwise.
- Key write: compares `out_port` against the key parameters.
  - KEY_UP → `sumar`; KEY_DOWN → `restar`; KEY_LEFT → `izquierda`; KEY_RIGHT → `derecha`.
  - Each pulse is exactly one cycle. There is no pulse on a non-write cycle, even if the last key value matched.
  - Unlisted codes have no effect.
- KEY_INSTR inverts `instrucciones` once per write. This is a flop, not a latch.
- KEY_RST loads the counter with RESET_PULSE_CYCLES and drives `resetO`=1 while the counter is nonzero.
  - The counter decrements every cycle.
  - A KEY_RST write while active reloads the counter (retrigger). It does not toggle.
  - Counter width is clog2(RESET_PULSE_CYCLES+1).
- Events: a rising edge on `event_in[i]` (previous sample 0, current sample 1) sets `pending[i]`.
  - A write to IRQ_PORT_ID clears every `pending[i]` where `out_port[i]`=1.
  - If a set and a clear of the same bit fall in the same cycle, the set wins.
- Interrupt FSM, states IDLE, REQ, SERVICE:
  - IDLE → REQ when `pending`≠0; `interrupt`=1 in REQ.
  - REQ → SERVICE on `interrupt_ack`; `interrupt`=0 in SERVICE.
  - SERVICE → IDLE on any write to IRQ_PORT_ID.
  - IDLE → REQ again the next cycle if bits remain pending.
  - New events arriving during SERVICE stay pending and do not reassert `interrupt`.
- Read mux: `in_port` = {zero-pad, `pending`} when `port_id`==IRQ_PORT_ID, else `ext_in`. Reads have no side effects.

## Timing
- Reset asserted: all outputs and state go to 0 immediately. This covers `EstadoPort`=8'h00, `instrucciones`=0, `resetO`=0, counter 0, `pending`=0, FSM=IDLE, edge-detect history 0.
- Reset deasserted: operation starts at the first `clk` edge. An `event_in` held high through reset release produces no edge.
- Write at edge n:
  - `EstadoPort`, `instrucciones` and the pulse outputs update at edge n.
  - Pulses are visible in cycle n..n+1 only.
- KEY_RST at edge n: `resetO` is high for exactly RESET_PULSE_CYCLES cycles starting after edge n.
- Event edge sampled at edge n: `pending` is set at edge n, and `interrupt` rises at edge n+1.
- `interrupt_ack` at edge m: `interrupt` falls at edge m.
- Simultaneous key write and IRQ write are impossible, since there is one `port_id`. An ack and an IRQ-port write in the same cycle move the FSM REQ→SERVICE; the clear still applies.
- Reset mid-pulse aborts `resetO` at once.

## Test plan
- Reset with all inputs 0 → all outputs 0. Write port 8'h02 data 8'hA5 → `EstadoPort`=8'hA5 next edge, held 20 cycles.
- Key writes 8'h57, 8'h53, 8'h41, 8'h44 on consecutive cycles → `sumar`, `restar`, `izquierda`, `derecha` each high exactly one cycle, in order. Write 8'h99 → no pulse.
- Write 8'h49 twice with 5 idle cycles between → `instrucciones` goes 0→1→0. With no write, the value holds.
- Use RESET_PULSE_CYCLES=10. Write 8'h08, retrigger 4 cycles later → `resetO` high for 14 consecutive cycles. Assert `reset`=0 mid-pulse → `resetO` drops asynchronously.
- Raise `event_in[1]` → `pending`=2'b10, `interrupt` asserts. Pulse `interrupt_ack` → `interrupt` low. Raise `event_in[0]` in SERVICE → no reassert. Read port 8'h03 → `in_port`=8'h03. Write 8'h02 to port 8'h03 → `interrupt` reasserts; write 8'h01 → idle.
- Set and clear the same bit in the same cycle → the bit stays pending.
